// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill controller: default widths,
// FSM state codes and a saturating counter helper.
package icache_pkg;

    localparam int ISA_WIDTH_DEF      = 30;
    localparam int DDR_ADDR_WIDTH_DEF = 28;
    localparam int ADDR_WIDTH_MEM_DEF = 16;

    localparam int          STATE_W   = 3;
    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_LOOKUP = 3'd1;
    localparam logic [2:0]  ST_DRAIN  = 3'd2;
    localparam logic [2:0]  ST_REQ    = 3'd3;
    localparam logic [2:0]  ST_FILL   = 3'd4;
    localparam logic [2:0]  ST_DONE   = 3'd5;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ins_cache_ram.sv
// Single cache block storage: one write port, one registered read port.
// The read register is reset so the instruction output starts at zero.
module ins_cache_ram #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 72,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data only updates on a hit so the last fetched word stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ins_cache_refill_ctrl.sv
// Single-block instruction cache with DDR refill through a FWFT FIFO.
// Optional hit/miss performance counters are enabled with ICACHE_PERF_CNT_EN.
module ins_cache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ISA_WIDTH      = ISA_WIDTH_DEF,
    parameter int DDR_ADDR_WIDTH = DDR_ADDR_WIDTH_DEF,
    parameter int ADDR_WIDTH_MEM = ADDR_WIDTH_MEM_DEF,
    parameter int ISA_DEPTH      = 72
) (
    input  logic                      mem_clk,
    input  logic                      rst,
    input  logic                      ddr_init_input_finish,
    input  logic                      fetch_req,
    input  logic [ADDR_WIDTH_MEM-1:0] pc,
    output logic [ISA_WIDTH-1:0]      ins_out,
    output logic                      ins_valid,
    output logic                      ins_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
    output logic [7:0]                ins_read_len,
    input  logic                      ins_reading,
    input  logic                      ddr_to_ic_fifo_empty,
    input  logic [ISA_WIDTH-1:0]      ic_fifo_dout,
    output logic                      rd_en_ic_fifo
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [15:0]               hit_cnt,
    output logic [15:0]               miss_cnt
`endif
);

    localparam int AW = $clog2(ISA_DEPTH);

    logic [STATE_W-1:0]        state;
    logic                      blk_valid;
    logic [ADDR_WIDTH_MEM-1:0] base;
    logic [ADDR_WIDTH_MEM-1:0] miss_pc;
    logic [AW-1:0]             wr_ptr;
    logic [ADDR_WIDTH_MEM-1:0] offset;
    logic                      hit;
    logic                      hit_acc;
    logic                      miss_det;
    logic                      ram_we;

    // pc below base wraps to a large unsigned offset and therefore misses.
    assign offset   = pc - base;
    assign hit      = blk_valid && (offset < ADDR_WIDTH_MEM'(ISA_DEPTH));
    assign hit_acc  = (state == ST_LOOKUP) && fetch_req && hit;
    assign miss_det = (state == ST_LOOKUP) && fetch_req && !hit;
    assign ram_we   = (state == ST_FILL) && rd_en_ic_fifo;

    always_comb begin
        rd_en_ic_fifo = 1'b0;
        if ((state == ST_DRAIN) || (state == ST_FILL)) begin
            rd_en_ic_fifo = !ddr_to_ic_fifo_empty;
        end else begin
            rd_en_ic_fifo = 1'b0;
        end
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            blk_valid     <= 1'b0;
            base          <= '0;
            miss_pc       <= '0;
            wr_ptr        <= '0;
            ins_valid     <= 1'b0;
            ins_read_req  <= 1'b0;
            ins_read_addr <= '0;
            ins_read_len  <= 8'd0;
        end else begin
            ins_valid <= hit_acc;
            case (state)
                ST_IDLE: begin
                    if (ddr_init_input_finish) begin
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (miss_det) begin
                        miss_pc   <= pc;
                        blk_valid <= 1'b0;
                        if (ddr_to_ic_fifo_empty) begin
                            state         <= ST_REQ;
                            ins_read_req  <= 1'b1;
                            ins_read_addr <= DDR_ADDR_WIDTH'({pc, 3'b000});
                            ins_read_len  <= 8'(ISA_DEPTH);
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ddr_to_ic_fifo_empty) begin
                        state         <= ST_REQ;
                        ins_read_req  <= 1'b1;
                        ins_read_addr <= DDR_ADDR_WIDTH'({miss_pc, 3'b000});
                        ins_read_len  <= 8'(ISA_DEPTH);
                    end
                end
                ST_REQ: begin
                    if (ins_reading) begin
                        ins_read_req <= 1'b0;
                        state        <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Leaving on the last pop keeps the pop count at exactly one block.
                    if (rd_en_ic_fifo) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (wr_ptr == AW'(ISA_DEPTH - 1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    base      <= miss_pc;
                    blk_valid <= 1'b1;
                    wr_ptr    <= '0;
                    state     <= ST_LOOKUP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else begin
            if (hit_acc) begin
                hit_cnt <= sat_inc16(hit_cnt);
            end
            if (miss_det) begin
                miss_cnt <= sat_inc16(miss_cnt);
            end
        end
    end
`endif

    ins_cache_ram #(
        .WIDTH (ISA_WIDTH),
        .DEPTH (ISA_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (mem_clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (ic_fifo_dout),
        .re    (hit_acc),
        .raddr (offset[AW-1:0]),
        .rdata (ins_out)
    );

endmodule

// File: doc/ins_cache_refill_ctrl.md
INS_CACHE_REFILL_CTRL -- requirements
Module: ins_cache_refill_ctrl

Interface
REQ-001 Parameter ISA_WIDTH, default 30, instruction word width.
REQ-002 Parameter DDR_ADDR_WIDTH, default 28, DDR burst address width.
REQ-003 Parameter ADDR_WIDTH_MEM, default 16, program-counter width.
REQ-004 Parameter ISA_DEPTH, default 72, cache block size in instructions (2..255).
REQ-005 Ports, one clock, reset asynchronous active-high:
 mem_clk  in  1  clock
 rst  in  1  asynchronous active-high reset
 ddr_init_input_finish  in  1  DDR preload done; no refill before it is 1
 fetch_req  in  1  core fetch request, held until ins_valid
 pc  in  ADDR_WIDTH_MEM  fetch address
 ins_out  out  ISA_WIDTH  fetched instruction
 ins_valid  out  1  one-cycle strobe, ins_out valid
 ins_read_req  out  1  refill request to DDR interface
 ins_read_addr  out  DDR_ADDR_WIDTH  refill start address
 ins_read_len  out  8  refill beat count
 ins_reading  in  1  DDR interface accepted the request
 ddr_to_ic_fifo_empty  in  1  refill FIFO empty
 ic_fifo_dout  in  ISA_WIDTH  refill FIFO head (first-word-fall-through)
 rd_en_ic_fifo  out  1  refill FIFO pop

Function
REQ-006 States IDLE, LOOKUP, DRAIN, REQ, FILL, DONE; reset state IDLE.
REQ-007 IDLE -> LOOKUP once ddr_init_input_finish = 1; no other exit.
REQ-008 Block register base (ADDR_WIDTH_MEM) and valid bit; offset = pc - base, unsigned, modulo 2^ADDR_WIDTH_MEM.
REQ-009 Hit iff valid and offset < ISA_DEPTH; pc < base wraps to a large offset and misses.
REQ-010 LOOKUP hit: ins_out = RAM[offset], ins_valid = 1 exactly one cycle after fetch_req sampled; back-to-back hits give one instruction per cycle.
REQ-011 LOOKUP miss: fifo empty -> REQ, else -> DRAIN; ins_valid stays 0.
REQ-012 DRAIN: rd_en_ic_fifo = 1 while fifo non-empty, data discarded; -> REQ on first cycle empty.
REQ-013 REQ: ins_read_req = 1, ins_read_addr = zero-extended {pc, 3'b000}, ins_read_len = ISA_DEPTH, valid <= 0; hold until ins_reading = 1, then drop ins_read_req next cycle and -> FILL.
REQ-014 FILL: rd_en_ic_fifo = !ddr_to_ic_fifo_empty; each pop writes ic_fifo_dout to RAM[wr_ptr], wr_ptr++; FIFO empty stalls with no write.
REQ-015 FILL -> DONE after pop number ISA_DEPTH; popping never exceeds ISA_DEPTH.
REQ-016 DONE: base <= missed pc, valid <= 1, wr_ptr <= 0, -> LOOKUP; pending fetch_req then hits.
REQ-017 pc/fetch_req changes during DRAIN/REQ/FILL are ignored; block refills for the pc latched at miss.
REQ-018 rd_en_ic_fifo never asserts while ddr_to_ic_fifo_empty = 1.

Reset
REQ-019 Reset values: state IDLE, valid 0, base 0, wr_ptr 0, ins_out 0, ins_valid 0, ins_read_req 0, ins_read_addr 0, ins_read_len 0, rd_en_ic_fifo 0; RAM contents not reset.
REQ-020 Reset mid-REQ/FILL aborts the refill; partial block never marked valid.

Configuration
REQ-021 Macro ICACHE_PERF_CNT_EN defined: add outputs hit_cnt and miss_cnt (16 bits each, reset 0, +1 per hit strobe / per miss detection, saturate at 16'hFFFF); undefined: ports and logic absent, behaviour otherwise identical.

Structure
REQ-022 Shared package icache_pkg: state enumeration, ISA_WIDTH, DDR_ADDR_WIDTH, ADDR_WIDTH_MEM defaults.
REQ-023 One sub-module ins_cache_ram: ISA_DEPTH x ISA_WIDTH, one write port, one synchronous read port.

Verification
REQ-024 Reset, ddr_init_input_finish = 1, fetch pc = 0 -> DRAIN skipped, ins_read_req with addr 0, len 72; after 72 pops, ins_valid with RAM[0].
REQ-025 After block base 0: fetch pc 71 -> hit, latency 1; fetch pc 72 -> miss, ins_read_addr 0x240.
REQ-026 FIFO empty every other cycle during FILL -> exactly 72 writes, correct order, no pop while empty.
REQ-027 Miss with 5 stale words in FIFO -> 5 discard pops, then REQ.
REQ-028 rst pulsed at pop 30 of FILL -> all outputs reset, next fetch misses and refills.
REQ-029 ICACHE_PERF_CNT_EN defined: 1 miss + 10 hits -> miss_cnt 1, hit_cnt 10; counter preset 16'hFFFF stays after hit.
